// File: rtl/cskip_mpadd_arb.sv
`default_nettype none
// ============================================================================
// Module      : cskip_mpadd_arb
// Description : Round-robin arbiter and multi-precision sequencer sharing one
//               32-bit carry-skip adder (four 8-bit Brent-Kung blocks).
// Revision    : 1.0 - initial release
// ============================================================================
module cskip_mpadd_arb #(
    parameter int NREQ = 4,
    parameter int LW   = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*LW-1:0]  len,
    input  logic [NREQ-1:0]     cin_req,
    input  logic [NREQ-1:0]     word_valid,
    input  logic [NREQ*32-1:0]  a,
    input  logic [NREQ*32-1:0]  b,
    output logic [NREQ-1:0]     word_ready,
    output logic [NREQ-1:0]     gnt,
    output logic                sum_valid,
    output logic [31:0]         sum,
    output logic [IDW-1:0]      sum_id,
    output logic                sum_last,
    output logic                cout,
    input  logic                out_ready,
    output logic                busy
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_next_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [LW-1:0]  r_rem;
    logic           r_carry;
    logic           r_sum_valid;
    logic [31:0]    r_sum;
    logic [IDW-1:0] r_sum_id;
    logic           r_sum_last;
    logic           r_cout;

    logic           w_found;
    logic [IDW-1:0] w_sel_id;
    logic [LW-1:0]  w_sel_len;
    logic [31:0]    w_opa;
    logic [31:0]    w_opb;
    logic [31:0]    w_sum;
    logic           w_add_cout;
    logic           w_run;
    logic           w_take;
    logic           w_last;

    // Returns {block_propagate, carry_out, sum[7:0]} of an 8-bit Brent-Kung adder.
    function automatic logic [9:0] bk8_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] gg;
        logic [7:0] pp;
        logic [7:0] s;
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pp = p;
        for (int i = 1; i < 8; i += 2) begin
            gg[i] = gg[i] | (pp[i] & gg[i-1]);
            pp[i] = pp[i] & pp[i-1];
        end
        for (int i = 3; i < 8; i += 4) begin
            gg[i] = gg[i] | (pp[i] & gg[i-2]);
            pp[i] = pp[i] & pp[i-2];
        end
        gg[7] = gg[7] | (pp[7] & gg[3]);
        pp[7] = pp[7] & pp[3];
        gg[5] = gg[5] | (pp[5] & gg[3]);
        pp[5] = pp[5] & pp[3];
        for (int i = 2; i < 8; i += 2) begin
            gg[i] = gg[i] | (pp[i] & gg[i-1]);
            pp[i] = pp[i] & pp[i-1];
        end
        s[0] = p[0] ^ ci;
        for (int i = 1; i < 8; i++) begin
            s[i] = p[i] ^ (gg[i-1] | (pp[i-1] & ci));
        end
        return {pp[7], gg[7] | (pp[7] & ci), s};
    endfunction

    assign w_opa = a[r_id*32 +: 32];
    assign w_opb = b[r_id*32 +: 32];

    // Block carry skips straight through when every bit of the block propagates.
    always_comb begin
        logic [9:0] w_blk;
        logic       w_chain;
        w_sum   = '0;
        w_chain = r_carry;
        for (int k = 0; k < 4; k++) begin
            w_blk           = bk8_add(w_opa[8*k +: 8], w_opb[8*k +: 8], w_chain);
            w_sum[8*k +: 8] = w_blk[7:0];
            w_chain         = w_blk[9] ? w_chain : w_blk[8];
        end
        w_add_cout = w_chain;
    end

    always_comb begin
        logic [IDW:0] w_pos;
        w_found  = 1'b0;
        w_sel_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_pos >= (IDW+1)'(NREQ)) begin
                w_pos = w_pos - (IDW+1)'(NREQ);
            end
            if (!w_found && req[w_pos[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_sel_id = w_pos[IDW-1:0];
            end
        end
    end

    assign w_sel_len = len[w_sel_id*LW +: LW];
    assign w_run     = (r_state == c_S_RUN);
    assign w_take    = w_run & word_valid[r_id] & (~r_sum_valid | out_ready);
    assign w_last    = (r_rem == LW'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (w_found)          w_next_state = c_S_RUN;
            c_S_RUN:  if (w_take && w_last) w_next_state = c_S_IDLE;
            default:                        w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_rem       <= '0;
            r_carry     <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum       <= '0;
            r_sum_id    <= '0;
            r_sum_last  <= 1'b0;
            r_cout      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (!w_run && w_found) begin
                r_id    <= w_sel_id;
                r_rem   <= (w_sel_len == '0) ? LW'(1) : w_sel_len;
                r_carry <= cin_req[w_sel_id];
            end
            if (w_take) begin
                r_sum_valid <= 1'b1;
                r_sum       <= w_sum;
                r_sum_id    <= r_id;
                r_sum_last  <= w_last;
                r_cout      <= w_add_cout;
                r_carry     <= w_add_cout;
                r_rem       <= r_rem - LW'(1);
                if (w_last) begin
                    r_ptr <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);
                end
            end else if (r_sum_valid && out_ready) begin
                r_sum_valid <= 1'b0;
            end
        end
    end

    assign gnt        = w_run  ? (NREQ'(1) << r_id) : '0;
    assign word_ready = w_take ? (NREQ'(1) << r_id) : '0;
    assign busy       = w_run;
    assign sum_valid  = r_sum_valid;
    assign sum        = r_sum;
    assign sum_id     = r_sum_id;
    assign sum_last   = r_sum_last;
    assign cout       = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cskip_mpadd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cskip_mpadd_arb
// Description : Directed scoreboard bench for cskip_mpadd_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cskip_mpadd_arb;

    localparam int NREQ = 4;
    localparam int LW   = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
        logic           cout;
        logic [31:0]    sum;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*LW-1:0]  len;
    logic [NREQ-1:0]     cin_req;
    logic [NREQ-1:0]     word_valid;
    logic [NREQ*32-1:0]  a;
    logic [NREQ*32-1:0]  b;
    logic [NREQ-1:0]     word_ready;
    logic [NREQ-1:0]     gnt;
    logic                sum_valid;
    logic [31:0]         sum;
    logic [IDW-1:0]      sum_id;
    logic                sum_last;
    logic                cout;
    logic                out_ready;
    logic                busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e_main;
    exp_t e_mon;
    logic [NREQ-1:0] g;

    cskip_mpadd_arb #(.NREQ(NREQ), .LW(LW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .len        (len),
        .cin_req    (cin_req),
        .word_valid (word_valid),
        .a          (a),
        .b          (b),
        .word_ready (word_ready),
        .gnt        (gnt),
        .sum_valid  (sum_valid),
        .sum        (sum),
        .sum_id     (sum_id),
        .sum_last   (sum_last),
        .cout       (cout),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input int n, input logic [255:0] aw,
                            input logic [255:0] bw, input logic cin);
        logic        c;
        logic [32:0] t;
        exp_t        e;
        c = cin;
        for (int i = 0; i < n; i++) begin
            t      = {1'b0, aw[i*32 +: 32]} + {1'b0, bw[i*32 +: 32]} + {32'b0, c};
            e.id   = id[IDW-1:0];
            e.last = (i == n-1);
            e.cout = t[32];
            e.sum  = t[31:0];
            sb.push_back(e);
            c = t[32];
        end
    endtask

    task automatic feed(input int id, input int n, input logic [255:0] aw,
                        input logic [255:0] bw, input int gap_at, input int gap_len);
        logic ok;
        int   cnt;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                word_valid[id] = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
            a[id*32 +: 32] = aw[i*32 +: 32];
            b[id*32 +: 32] = bw[i*32 +: 32];
            word_valid[id] = 1'b1;
            cnt = 0;
            ok  = 1'b0;
            while (!ok && cnt < 50) begin
                @(negedge clk);
                ok = word_ready[id];
                @(posedge clk);
                #1;
                cnt++;
            end
            check("feed_handshake", ok, 1);
        end
        word_valid[id] = 1'b0;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] gv);
        int n;
        n = 0;
        while (gnt == '0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("gnt_wait", n < 50, 1);
        gv = gnt;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sum_valid || sb.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_wait", n < 100, 1);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},        gnt, 0);
        check({tag, "_word_ready"}, word_ready, 0);
        check({tag, "_sum_valid"},  sum_valid, 0);
        check({tag, "_sum"},        sum, 0);
        check({tag, "_sum_id"},     sum_id, 0);
        check({tag, "_sum_last"},   sum_last, 0);
        check({tag, "_cout"},       cout, 0);
        check({tag, "_busy"},       busy, 0);
    endtask

    // Result scoreboard: pops one expected word per accepted output beat.
    always @(negedge clk) begin
        if (rst_n && sum_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check("sum",      sum,      e_mon.sum);
                check("sum_id",   sum_id,   e_mon.id);
                check("sum_last", sum_last, e_mon.last);
                if (e_mon.last) check("cout", cout, e_mon.cout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; len = '0; cin_req = '0; word_valid = '0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two-word add with carry across words
        len[0 +: 4] = 4'd2;
        push_exp(0, 2, {192'h0, 32'h0, 32'hFFFFFFFF}, {192'h0, 32'h0, 32'h00000001}, 1'b0);
        req = 4'b0001;
        @(posedge clk); #1;
        check("t1_gnt_latency", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        req = '0;
        feed(0, 2, {192'h0, 32'h0, 32'hFFFFFFFF}, {192'h0, 32'h0, 32'h00000001}, -1, 0);
        wait_idle();

        // Full-skip carry path with cin=1
        len[4 +: 4] = 4'd1;
        cin_req = 4'b0010;
        push_exp(1, 1, {224'h0, 32'hFFFFFFFF}, 256'h0, 1'b1);
        req = 4'b0010;
        wait_gnt(g);
        check("t2_gnt", g, 4'b0010);
        req = '0;
        feed(1, 1, {224'h0, 32'hFFFFFFFF}, 256'h0, -1, 0);
        wait_idle();
        cin_req = '0;

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin order over all requesters, then a sparse pattern
        len = 16'h1111;
        for (int i = 0; i < NREQ; i++) begin
            a[i*32 +: 32] = 32'h01010101 * (i + 1);
            b[i*32 +: 32] = 32'h00000010 + i;
        end
        for (int i = 0; i < NREQ; i++)
            push_exp(i, 1, {224'h0, a[i*32 +: 32]}, {224'h0, b[i*32 +: 32]}, 1'b0);
        word_valid = 4'b1111;
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            @(posedge clk); #1;
            check("t3_gnt_order", gnt, 4'b0001 << k);
            req[k] = 1'b0;
            @(posedge clk); #1;
            check("t3_idle_gap", gnt, 0);
        end
        push_exp(0, 1, {224'h0, a[31:0]}, {224'h0, b[31:0]}, 1'b0);
        push_exp(2, 1, {224'h0, a[95:64]}, {224'h0, b[95:64]}, 1'b0);
        req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("t3b_gnt_order", gnt, 4'b0001 << (2*k));
            req[2*k] = 1'b0;
            @(posedge clk); #1;
            check("t3b_idle_gap", gnt, 0);
        end
        word_valid = '0;
        wait_idle();

        // Four words with output backpressure after the first result
        len[8 +: 4] = 4'd4;
        push_exp(2, 4, {32'h0, 32'hFFFFFFFF, 32'h0, 32'h00000005,
                        32'h0, 32'h7FFFFFFF, 32'h0, 32'h10000001} >> 0,
                       256'h0, 1'b0);
        sb = {};
        push_exp(2, 4, {128'h0, 32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h10000001},
                       {128'h0, 32'h00000001, 32'hFFFFFFFB, 32'h00000000, 32'h20000002}, 1'b0);
        out_ready = 1'b0;
        req = 4'b0100;
        fork
            feed(2, 4, {128'h0, 32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h10000001},
                       {128'h0, 32'h00000001, 32'hFFFFFFFB, 32'h00000000, 32'h20000002}, -1, 0);
            begin
                int n;
                n = 0;
                while (!sum_valid && n < 50) begin
                    @(posedge clk); #2;
                    n++;
                end
                check("t4_first_result", sum_valid, 1);
                req = '0;
                repeat (3) begin
                    check("t4_hold_valid", sum_valid, 1);
                    check("t4_hold_sum",   sum, 32'h30000003);
                    check("t4_hold_ready", word_ready, 0);
                    @(posedge clk); #2;
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset mid-operation abandons the remaining words
        len[12 +: 4] = 4'd3;
        e_main.id = 2'd3; e_main.last = 1'b0; e_main.cout = 1'b0; e_main.sum = 32'h23456789;
        sb.push_back(e_main);
        req = 4'b1000;
        wait_gnt(g);
        check("t5_gnt", g, 4'b1000);
        req = '0;
        feed(3, 1, {224'h0, 32'h12345678}, {224'h0, 32'h11111111}, -1, 0);
        check("t5_busy_before_reset", busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        check("t5_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        len[0 +: 4] = 4'd1;
        len[12 +: 4] = 4'd1;
        push_exp(0, 1, {224'h0, 32'h00000005}, {224'h0, 32'h00000006}, 1'b0);
        req = 4'b1001;
        wait_gnt(g);
        check("t5_gnt_after_reset", g, 4'b0001);
        req = '0;
        feed(0, 1, {224'h0, 32'h00000005}, {224'h0, 32'h00000006}, -1, 0);
        wait_idle();

        // Three words with a two-cycle word_valid gap; carry must survive the stall
        len[0 +: 4] = 4'd3;
        push_exp(0, 3, {160'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                       {160'h0, 32'h0, 32'h0, 32'h00000001}, 1'b0);
        req = 4'b0001;
        wait_gnt(g);
        check("t6_gnt", g, 4'b0001);
        req = '0;
        feed(0, 3, {160'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                   {160'h0, 32'h0, 32'h0, 32'h00000001}, 2, 2);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cskip_mpadd_arb.md
Name: cskip_mpadd_arb

Overview:
Round-robin arbiter and multi-precision sequencer for one shared 32-bit carry-skip adder (four 8-bit Brent-Kung blocks with skip muxes). Up to NREQ requesters each submit an N-word addition. The block grants one requester at a time and streams its operand words through the single adder instance, one word per cycle. The carry is registered between words, and the result words go out on a registered output port with backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
LW, 4, width of the per-request word-count field
IDW, 2, width of the requester ID; must equal clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request pending, one bit per requester
len  input  NREQ*LW  word count per requester; requester i uses bits [i*LW +: LW]
cin_req  input  NREQ  initial carry-in per requester
word_valid  input  NREQ  operand word pair present, per requester
a  input  NREQ*32  operand A word per requester, least-significant word first
b  input  NREQ*32  operand B word per requester
word_ready  output  NREQ  word pair consumed this cycle; one-hot or zero
gnt  output  NREQ  current grant; one-hot or zero
sum_valid  output  1  result word valid
sum  output  32  result word
sum_id  output  IDW  requester that owns the result word
sum_last  output  1  final word of the request
cout  output  1  final carry-out; meaningful only when sum_valid and sum_last are both high
out_ready  input  1  downstream accepts the result word
busy  output  1  high while in RUN

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE. gnt=0, word_ready=0, sum_valid=0, sum=0, sum_id=0, sum_last=0, cout=0, busy=0. Round-robin pointer=0, carry register=0, remaining count=0. Reset mid-operation abandons the operation; no partial result is retained.
- FSM has two states, IDLE and RUN.
- IDLE:
  - If req is nonzero, select the first set bit searching upward from the pointer, with wrap-around.
  - Latch: id, remaining = len[id] (len 0 is treated as 1), carry = cin_req[id].
  - Go to RUN. gnt[id] rises in the first RUN cycle, so grant latency is 1 cycle after req is sampled.
- RUN, each cycle:
  - Define take = word_valid[id] & (~sum_valid | out_ready).
  - word_ready[id] = take, combinational. All other word_ready bits are 0.
- On take:
  - The adder computes {a[id], b[id], carry}.
  - Result is registered: sum_valid<=1, sum<=s, sum_id<=id, sum_last<=(remaining==1), cout<=adder cout.
  - carry<=adder cout; remaining<=remaining-1.
  - If remaining==1, go to IDLE, pointer<=id+1 mod NREQ, and gnt drops the next cycle.
- Output handshake: if sum_valid & out_ready & ~take, then sum_valid<=0. sum, sum_id, sum_last and cout hold stable while sum_valid=1 and out_ready=0.
- Throughput is 1 word per cycle. Result latency is 1 cycle after take.
- The block ignores req deassertion during RUN: the operation runs all remaining words. It ignores len and cin_req changes after the latch.
- A requester whose req is still high after completion is eligible only after the other requesters in round-robin order.
- Arbitration happens only in IDLE. A grant never changes mid-operation. There is a minimum of 1 idle cycle between operations.
- Adder arithmetic is modulo 2^32 per word. The carry chain across words is exact, so the N-word result equals (A+B+cin) mod 2^(32N), and cout is bit 32N.
- A word_valid gap stalls the operation: no take, and carry and remaining hold.

Test Plan:
- Req0 only, len=2, cin=0; words (FFFFFFFF,00000001) then (00000000,00000000) -> sum 00000000 (last=0), then 00000001 (last=1, cout=0), sum_id=0.
- Req1, len=1, cin=1, a=FFFFFFFF, b=00000000 (full-skip path) -> sum=00000000, cout=1, sum_last=1, sum_id=1.
- req=1111, each len=1 -> grants in order 0,1,2,3. Then req=0101 -> order 0,2. Each gnt is one-hot with one IDLE cycle between grants.
- Req2, len=4; out_ready held low for 3 cycles after the first result -> sum is held stable, word_ready stays 0, all 4 words are delivered in order, and none are lost or duplicated.
- rst_n pulsed low mid-RUN (req3, remaining=2) -> all outputs 0 asynchronously. After release with req=1001, grant goes to 0 first.
- Req0, len=3 with word_valid low for 2 cycles between words 1 and 2 -> carry is preserved: A=0x0_FFFFFFFF_FFFFFFFF, B=1 gives words 0,0,1, and cout=0 on the last word.
